// File: rtl/simt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : simt_scheduler
// Purpose  : Per-core control scheduler with SIMT branch divergence. Walks the
//            core through IDLE/FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE/DONE.
//            Divergent branches split the active-thread mask and push a
//            reconvergence entry. SYNC either switches to the pending path or
//            pops the entry and restores the pre-branch mask.
// Ports    : clk, reset (async, active-low)
//            start, thread_count            - kernel launch (sampled in IDLE)
//            fetch_valid                    - fetcher has an instruction
//            decoded_*                      - decoded instruction class
//            lsu_busy[T]                    - per-lane LSU busy
//            next_pc[T*PC_BITS]             - per-lane next PC
//            core_state, current_pc         - shared control state
//            active_mask[T]                 - lanes executing current instr
//            stack_depth                    - reconvergence stack occupancy
//            done, fault                    - kernel finished / error
// Revision : 1.0 - initial release
// ============================================================================
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int STACK_DEPTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic                                 fetch_valid,
    input  logic                                 decoded_mem_read_enable,
    input  logic                                 decoded_mem_write_enable,
    input  logic                                 decoded_branch,
    input  logic                                 decoded_sync,
    input  logic                                 decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]         lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]         active_mask,
    output logic [$clog2(STACK_DEPTH):0]         stack_depth,
    output logic                                 done,
    output logic                                 fault
);

    localparam int c_DW = $clog2(STACK_DEPTH) + 1;
    localparam int c_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [c_DW-1:0] c_FULL = c_DW'(STACK_DEPTH);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_DECODE  = 3'd2;
    localparam logic [2:0] c_REQUEST = 3'd3;
    localparam logic [2:0] c_WAIT    = 3'd4;
    localparam logic [2:0] c_EXECUTE = 3'd5;
    localparam logic [2:0] c_UPDATE  = 3'd6;
    localparam logic [2:0] c_DONE    = 3'd7;

    logic [2:0]                   r_state;
    logic [PC_BITS-1:0]           r_pc;
    logic [THREADS_PER_BLOCK-1:0] r_mask;
    logic [c_DW-1:0]              r_depth;
    logic                         r_done;
    logic                         r_fault;

    // Reconvergence stack: fall-through PC/mask, the mask before the split,
    // and whether the fall-through path still has to run.
    logic [PC_BITS-1:0]           r_stk_pc    [STACK_DEPTH];
    logic [THREADS_PER_BLOCK-1:0] r_stk_mask  [STACK_DEPTH];
    logic [THREADS_PER_BLOCK-1:0] r_stk_saved [STACK_DEPTH];
    logic [STACK_DEPTH-1:0]       r_stk_pend;

    logic [PC_BITS-1:0]           w_pc_inc;
    logic [PC_BITS-1:0]           w_lead_pc;
    logic [PC_BITS-1:0]           w_tk_pc;
    logic [THREADS_PER_BLOCK-1:0] w_ft;
    logic [THREADS_PER_BLOCK-1:0] w_tk;
    logic [THREADS_PER_BLOCK-1:0] w_start_mask;
    logic [c_IW-1:0]              w_top;
    logic [c_IW-1:0]              w_push_idx;
    logic                         w_mem_op;
    logic                         w_lanes_idle;

    assign w_pc_inc     = r_pc + PC_BITS'(1);
    assign w_top        = c_IW'(r_depth - c_DW'(1));
    assign w_push_idx   = c_IW'(r_depth);
    assign w_mem_op     = decoded_mem_read_enable | decoded_mem_write_enable;
    // Only active lanes hold up WAIT; masked-off lanes may report anything.
    assign w_lanes_idle = (lsu_busy & r_mask) == '0;

    // Lane classification and lowest-index PC selection. Loops run from the
    // top lane down so the lowest matching lane is the last (winning) write.
    always_comb begin
        w_ft         = '0;
        w_start_mask = '0;
        w_lead_pc    = r_pc;
        w_tk_pc      = r_pc;
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
            w_start_mask[i] = (i < int'(thread_count));
            if (r_mask[i]) begin
                w_lead_pc = next_pc[i*PC_BITS +: PC_BITS];
                if (next_pc[i*PC_BITS +: PC_BITS] == w_pc_inc) begin
                    w_ft[i] = 1'b1;
                end
            end
        end
        w_tk = r_mask & ~w_ft;
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
            if (w_tk[i]) begin
                w_tk_pc = next_pc[i*PC_BITS +: PC_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_pc       <= '0;
            r_mask     <= '0;
            r_depth    <= '0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_stk_pend <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stk_pc[i]    <= '0;
                r_stk_mask[i]  <= '0;
                r_stk_saved[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (thread_count == '0) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_mask  <= w_start_mask;
                            r_pc    <= '0;
                            r_state <= c_FETCH;
                        end
                    end
                end
                c_FETCH: begin
                    if (fetch_valid) begin
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE:  r_state <= c_REQUEST;
                c_REQUEST: r_state <= c_WAIT;
                c_WAIT: begin
                    if (!w_mem_op || w_lanes_idle) begin
                        r_state <= c_EXECUTE;
                    end
                end
                c_EXECUTE: r_state <= c_UPDATE;
                c_UPDATE: begin
                    r_state <= c_FETCH;
                    if (decoded_ret) begin
                        // Returning while paths are still outstanding is an error.
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        if (r_depth != '0) begin
                            r_fault <= 1'b1;
                        end
                    end else if (decoded_branch) begin
                        if (w_ft == '0 || w_tk == '0) begin
                            r_pc <= w_lead_pc;
                        end else if (r_depth == c_FULL) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            // Run the taken path first; fall-through waits on the stack.
                            r_stk_pc[w_push_idx]    <= w_pc_inc;
                            r_stk_mask[w_push_idx]  <= w_ft;
                            r_stk_saved[w_push_idx] <= r_mask;
                            r_stk_pend[w_push_idx]  <= 1'b1;
                            r_depth                 <= r_depth + c_DW'(1);
                            r_mask                  <= w_tk;
                            r_pc                    <= w_tk_pc;
                        end
                    end else if (decoded_sync) begin
                        if (r_depth == '0) begin
                            r_pc <= w_pc_inc;
                        end else if (r_stk_pend[w_top]) begin
                            r_pc              <= r_stk_pc[w_top];
                            r_mask            <= r_stk_mask[w_top];
                            r_stk_pend[w_top] <= 1'b0;
                        end else begin
                            r_mask  <= r_stk_saved[w_top];
                            r_pc    <= w_pc_inc;
                            r_depth <= r_depth - c_DW'(1);
                        end
                    end else begin
                        r_pc <= w_lead_pc;
                    end
                end
                c_DONE:  r_state <= c_DONE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign core_state  = r_state;
    assign current_pc  = r_pc;
    assign active_mask = r_mask;
    assign stack_depth = r_depth;
    assign done        = r_done;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_simt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_simt_scheduler
// Purpose  : Self-checking bench for simt_scheduler. Directed scenarios plus
//            randomized programs checked against a queue-based divergence
//            model kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simt_scheduler;

    localparam int T  = 4;
    localparam int PB = 8;
    localparam int SD = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_REQ    = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_EXEC   = 3'd5;
    localparam logic [2:0] ST_UPDATE = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    localparam int K_ADD = 0, K_LDR = 1, K_STR = 2, K_BR = 3, K_SYNC = 4, K_RET = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [$clog2(T):0]      thread_count;
    logic                    fetch_valid;
    logic                    dec_ld, dec_st, dec_br, dec_sync, dec_ret;
    logic [T-1:0]            lsu_busy;
    logic [T*PB-1:0]         next_pc;
    logic [2:0]              core_state;
    logic [PB-1:0]           current_pc;
    logic [T-1:0]            active_mask;
    logic [$clog2(SD):0]     stack_depth;
    logic                    done;
    logic                    fault;

    always #5 clk = ~clk;

    simt_scheduler #(
        .THREADS_PER_BLOCK(T),
        .PC_BITS          (PB),
        .STACK_DEPTH      (SD)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .thread_count            (thread_count),
        .fetch_valid             (fetch_valid),
        .decoded_mem_read_enable (dec_ld),
        .decoded_mem_write_enable(dec_st),
        .decoded_branch          (dec_br),
        .decoded_sync            (dec_sync),
        .decoded_ret             (dec_ret),
        .lsu_busy                (lsu_busy),
        .next_pc                 (next_pc),
        .core_state              (core_state),
        .current_pc              (current_pc),
        .active_mask             (active_mask),
        .stack_depth             (stack_depth),
        .done                    (done),
        .fault                   (fault)
    );

    // Reference model: shared PC/mask plus a queue of reconvergence entries.
    typedef struct packed {
        logic [PB-1:0] pc;
        logic [T-1:0]  mask;
        logic [T-1:0]  saved;
        logic          pend;
    } entry_t;

    entry_t        stk[$];
    logic [PB-1:0] m_pc;
    logic [T-1:0]  m_mask;
    logic          m_done;
    logic          m_fault;
    logic [2:0]    m_state;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [T*PB-1:0] pack4(input logic [PB-1:0] a, input logic [PB-1:0] b,
                                              input logic [PB-1:0] c, input logic [PB-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [PB-1:0] lane_pc(input logic [T*PB-1:0] v, input int i);
        return v[i*PB +: PB];
    endfunction

    function automatic int lowest(input logic [T-1:0] m);
        for (int i = 0; i < T; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_pc    = '0;
        m_mask  = '0;
        m_done  = 1'b0;
        m_fault = 1'b0;
        m_state = ST_IDLE;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(core_state),  32'(m_state));
        chk({tag, ".pc"},    32'(current_pc),  32'(m_pc));
        chk({tag, ".mask"},  32'(active_mask), 32'(m_mask));
        chk({tag, ".depth"}, 32'(stack_depth), 32'(stk.size()));
        chk({tag, ".done"},  32'(done),        32'(m_done));
        chk({tag, ".fault"}, 32'(fault),       32'(m_fault));
    endtask

    task automatic clear_decode();
        dec_ld = 0; dec_st = 0; dec_br = 0; dec_sync = 0; dec_ret = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; fetch_valid = 1'b0; clear_decode();
        lsu_busy = '0; next_pc = '0; thread_count = '0;
        step(); step();
        model_reset();
        check_all("reset");
        reset = 1'b1;
        step();
        check_all("idle");
    endtask

    task automatic do_start(input int tc);
        thread_count = 3'(tc);
        start = 1'b1;
        step();
        start = 1'b0;
        if (tc == 0) begin
            m_state = ST_DONE;
            m_done  = 1'b1;
        end else begin
            m_state = ST_FETCH;
            m_pc    = '0;
            m_mask  = '0;
            for (int i = 0; i < T; i++) if (i < tc) m_mask[i] = 1'b1;
        end
        check_all("start");
    endtask

    task automatic model_update(input int kind, input logic [T*PB-1:0] npc);
        logic [PB-1:0] inc;
        logic [T-1:0]  ft, tk;
        entry_t        e;
        inc     = m_pc + PB'(1);
        m_state = ST_FETCH;
        case (kind)
            K_RET: begin
                m_state = ST_DONE;
                m_done  = 1'b1;
                m_fault = (stk.size() != 0);
            end
            K_BR: begin
                ft = '0;
                for (int i = 0; i < T; i++) if (m_mask[i] && lane_pc(npc, i) == inc) ft[i] = 1'b1;
                tk = m_mask & ~ft;
                if (ft == '0 || tk == '0) begin
                    m_pc = lane_pc(npc, lowest(m_mask));
                end else if (stk.size() == SD) begin
                    m_state = ST_DONE;
                    m_done  = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    e.pc = inc; e.mask = ft; e.saved = m_mask; e.pend = 1'b1;
                    stk.push_back(e);
                    m_pc   = lane_pc(npc, lowest(tk));
                    m_mask = tk;
                end
            end
            K_SYNC: begin
                if (stk.size() == 0) begin
                    m_pc = inc;
                end else begin
                    e = stk.pop_back();
                    if (e.pend) begin
                        m_pc   = e.pc;
                        m_mask = e.mask;
                        e.pend = 1'b0;
                        stk.push_back(e);
                    end else begin
                        m_mask = e.saved;
                        m_pc   = inc;
                    end
                end
            end
            default: m_pc = lane_pc(npc, lowest(m_mask));
        endcase
    endtask

    // One full instruction pass FETCH..UPDATE. bc = cycles the active lanes
    // stay busy in WAIT; inact = busy bits reported by masked-off lanes.
    task automatic do_instr(input int kind, input logic [T*PB-1:0] npc, input int bc,
                            input logic [T-1:0] inact);
        int           n;
        logic [T-1:0] am;
        logic         mem;
        n = 0;
        while (core_state != ST_FETCH && n < 20) begin step(); n++; end
        chk("reach_fetch", 32'(core_state), 32'(ST_FETCH));
        am       = m_mask;
        mem      = (kind == K_LDR || kind == K_STR);
        dec_ld   = (kind == K_LDR);
        dec_st   = (kind == K_STR);
        dec_br   = (kind == K_BR);
        dec_sync = (kind == K_SYNC);
        dec_ret  = (kind == K_RET);
        next_pc  = npc;
        if (mem) lsu_busy = (bc > 0) ? (am | inact) : (~am & inact);
        else     lsu_busy = T'($urandom);
        fetch_valid = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) begin
            start = 1'($urandom);
            step();
            chk("fetch_hold", 32'(core_state), 32'(ST_FETCH));
        end
        fetch_valid = 1'b1;
        step();
        fetch_valid = 1'b0;
        chk("decode", 32'(core_state), 32'(ST_DECODE));
        step();
        chk("request", 32'(core_state), 32'(ST_REQ));
        step();
        chk("wait", 32'(core_state), 32'(ST_WAIT));
        if (mem) begin
            for (int k = 0; k < bc; k++) begin
                step();
                chk("wait_hold", 32'(core_state), 32'(ST_WAIT));
            end
            lsu_busy = ~am & inact;
        end
        step();
        chk("execute", 32'(core_state), 32'(ST_EXEC));
        step();
        chk("update", 32'(core_state), 32'(ST_UPDATE));
        step();
        start = 1'b0;
        clear_decode();
        model_update(kind, npc);
        check_all("instr");
    endtask

    function automatic logic [T*PB-1:0] gen_npc(input int kind);
        logic [T*PB-1:0] v;
        logic [PB-1:0]   inc, tgt;
        v   = (T*PB)'($urandom);
        inc = m_pc + PB'(1);
        tgt = ($urandom_range(0, 3) == 0) ? '1 : PB'($urandom);
        for (int i = 0; i < T; i++) begin
            if (m_mask[i]) begin
                if (kind == K_BR)
                    v[i*PB +: PB] = ($urandom_range(0, 1) == 1) ? inc : tgt;
                else if (kind != K_SYNC && kind != K_RET && $urandom_range(0, 3) != 0)
                    v[i*PB +: PB] = inc;
            end
        end
        return v;
    endfunction

    task automatic random_run();
        int kind, w;
        apply_reset();
        do_start($urandom_range(1, 7));
        for (int n = 0; n < 20 && !m_done; n++) begin
            w    = $urandom_range(0, 9);
            kind = (w < 3) ? K_ADD : (w < 4) ? K_LDR : (w < 5) ? K_STR : (w < 7) ? K_BR : K_SYNC;
            do_instr(kind, gen_npc(kind), $urandom_range(0, 4), T'($urandom));
        end
        if ($urandom_range(0, 3) != 0) begin
            while (!m_done && stk.size() != 0) do_instr(K_SYNC, gen_npc(K_SYNC), 0, '0);
        end
        if (!m_done) do_instr(K_RET, gen_npc(K_RET), 0, '0);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        chk("sticky_state", 32'(core_state), 32'(ST_DONE));
        chk("sticky_done",  32'(done),       32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();

        // Straight-line ADD, ADD, RET with all four lanes.
        do_start(4);
        do_instr(K_ADD, pack4(1, 1, 1, 1), 0, '0);
        chk("sl_pc1", 32'(current_pc), 32'd1);
        do_instr(K_ADD, pack4(2, 2, 2, 2), 0, '0);
        chk("sl_pc2", 32'(current_pc), 32'd2);
        do_instr(K_RET, pack4(3, 3, 3, 3), 0, '0);
        chk("sl_done",  32'(done),        32'd1);
        chk("sl_fault", 32'(fault),       32'd0);
        chk("sl_mask",  32'(active_mask), 32'hF);

        // Three live lanes, LDR busy five cycles, lane 3 busy throughout.
        apply_reset();
        do_start(3);
        chk("lsu_mask", 32'(active_mask), 32'h7);
        do_instr(K_LDR, pack4(1, 1, 1, 1), 5, 4'b1000);

        // Divergent branch and two-step reconvergence.
        apply_reset();
        do_start(4);
        do_instr(K_ADD, pack4(1, 1, 1, 1), 0, '0);
        do_instr(K_ADD, pack4(2, 2, 2, 2), 0, '0);
        do_instr(K_BR,  pack4(7, 7, 3, 3), 0, '0);
        chk("br_mask",  32'(active_mask), 32'h3);
        chk("br_pc",    32'(current_pc),  32'd7);
        chk("br_depth", 32'(stack_depth), 32'd1);
        do_instr(K_ADD,  pack4(8, 8, 0, 0), 0, '0);
        do_instr(K_ADD,  pack4(9, 9, 0, 0), 0, '0);
        do_instr(K_SYNC, pack4(0, 0, 0, 0), 0, '0);
        chk("sync1_mask", 32'(active_mask), 32'hC);
        chk("sync1_pc",   32'(current_pc),  32'd3);
        do_instr(K_ADD,  pack4(0, 0, 9, 9), 0, '0);
        do_instr(K_SYNC, pack4(0, 0, 0, 0), 0, '0);
        chk("sync2_mask",  32'(active_mask), 32'hF);
        chk("sync2_pc",    32'(current_pc),  32'd10);
        chk("sync2_depth", 32'(stack_depth), 32'd0);

        // Nested divergence beyond a two-entry stack.
        apply_reset();
        do_start(4);
        do_instr(K_BR, pack4(10, 10, 10, 1), 0, '0);
        do_instr(K_BR, pack4(20, 20, 11, 0), 0, '0);
        do_instr(K_BR, pack4(30, 21, 0, 0),  0, '0);
        chk("ovf_state", 32'(core_state), 32'(ST_DONE));
        chk("ovf_fault", 32'(fault),      32'd1);
        chk("ovf_done",  32'(done),       32'd1);

        // PC wrap through SYNC on an empty stack.
        apply_reset();
        do_start(4);
        do_instr(K_BR,   pack4(255, 255, 255, 255), 0, '0);
        do_instr(K_SYNC, pack4(5, 5, 5, 5),         0, '0);
        chk("wrap_pc", 32'(current_pc), 32'd0);

        // Zero threads finishes straight from IDLE.
        apply_reset();
        do_start(0);
        chk("tc0_state", 32'(core_state), 32'(ST_DONE));
        chk("tc0_done",  32'(done),       32'd1);

        // Asynchronous reset while waiting on memory with one stack entry.
        apply_reset();
        do_start(4);
        do_instr(K_BR, pack4(7, 7, 1, 1), 0, '0);
        dec_ld = 1'b1; lsu_busy = '1; next_pc = pack4(8, 8, 8, 8);
        fetch_valid = 1'b1;
        step();
        fetch_valid = 1'b0;
        step();
        step();
        chk("mr_wait",  32'(core_state),  32'(ST_WAIT));
        chk("mr_depth", 32'(stack_depth), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        step();
        reset = 1'b1;
        clear_decode();
        lsu_busy = '0;
        step();
        do_start(4);
        do_instr(K_ADD, pack4(1, 1, 1, 1), 0, '0);
        do_instr(K_RET, pack4(2, 2, 2, 2), 0, '0);

        for (int r = 0; r < 30; r++) random_run();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simt_scheduler.md
Name: simt_scheduler

Overview:
- Per-core control scheduler that adds SIMT branch divergence to the core's control FSM.
- Threads within a block may take different branch outcomes; each path runs serially under an active-thread mask and reconverges at a SYNC instruction.
- Sits between the fetcher/decoder, the per-thread LSUs and the per-thread PC units, and drives core_state, current_pc and active_mask to every thread lane.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes
PC_BITS, 8, program counter width
STACK_DEPTH, 4, reconvergence stack entries (nesting depth)

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  kernel start pulse/level, sampled only in IDLE
thread_count  input  $clog2(THREADS_PER_BLOCK)+1  live threads in block
fetch_valid  input  1  fetcher has instruction ready
decoded_mem_read_enable  input  1  current instr is LDR
decoded_mem_write_enable  input  1  current instr is STR
decoded_branch  input  1  current instr is BRnzp
decoded_sync  input  1  current instr is SYNC
decoded_ret  input  1  current instr is RET
lsu_busy  input  THREADS_PER_BLOCK  per-lane LSU not yet idle/done
next_pc  input  THREADS_PER_BLOCK*PC_BITS  per-lane next PC, lane i at [i*PC_BITS +: PC_BITS]
core_state  output  3  IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7
current_pc  output  PC_BITS  shared PC
active_mask  output  THREADS_PER_BLOCK  lanes executing current instr
stack_depth  output  $clog2(STACK_DEPTH)+1  current occupancy
done  output  1  kernel finished
fault  output  1  stack overflow or RET under divergence

Behaviour:
- Reset (reset=0, async): core_state=IDLE, current_pc=0, active_mask=0, stack empty, stack_depth=0, done=0, fault=0.
- IDLE: start=1 -> active_mask = lanes i<thread_count, current_pc=0, goto FETCH. If thread_count=0 -> DONE directly, done=1.
- FETCH: hold until fetch_valid=1, then DECODE. DECODE -> REQUEST -> WAIT, one cycle each.
- WAIT: if a mem op is decoded, stay until (lsu_busy & active_mask)==0. Inactive lanes' busy bits are ignored. Non-mem op: leave after one cycle. Then EXECUTE (1 cycle) -> UPDATE.
- UPDATE, evaluated in priority order:
  - RET: stack empty -> DONE, done=1. Stack non-empty -> DONE, done=1, fault=1.
  - BRANCH:
    - ft = active lanes with next_pc == current_pc+1; tk = active & ~ft.
    - tk==0 or ft==0 (uniform): current_pc = next_pc of lowest-index active lane; mask unchanged.
    - Divergent, stack full: DONE, done=1, fault=1.
    - Divergent, space available: push {pc=current_pc+1, mask=ft, saved=active_mask, pending=1}; active_mask=tk; current_pc=tk target (lowest tk lane).
  - SYNC:
    - Stack empty: current_pc+1, no-op.
    - Top pending=1: current_pc=top.pc, active_mask=top.mask, top.pending=0.
    - Top pending=0: pop; active_mask=top.saved; current_pc=current_pc+1.
  - Otherwise: current_pc = next_pc of lowest-index active lane.
  - After UPDATE (non-DONE) -> FETCH.
- PC arithmetic: modulo 2^PC_BITS; current_pc+1 wraps from all-ones to 0.
- DONE is sticky until reset; start is ignored outside IDLE.
- stack_depth updates in the same cycle as the push or pop.
- Reset mid-operation: all state cleared immediately, no handshake completion.

Test Plan:
- T=4, thread_count=4, straight-line ADD,ADD,RET: PCs 0->1->2, done=1 after RET UPDATE, fault=0, active_mask=4'b1111 throughout.
- thread_count=3, LDR with lsu_busy=4'b1000 held and lanes 0-2 busy for 5 cycles: WAIT exits exactly when lanes 0-2 clear; lane 3 busy ignored.
- BR at pc=2, lanes 0,1 next_pc=7, lanes 2,3 next_pc=3: active_mask=0011, pc=7, stack_depth=1. SYNC at pc=9 -> mask=1100, pc=3. SYNC at 9 again -> mask=1111, pc=10, depth=0.
- STACK_DEPTH=2, three nested divergent branches: third sets fault=1, done=1, core_state=DONE.
- start with thread_count=0 -> done=1 one cycle later, no FETCH state seen.
- Reset low in WAIT with depth=1 -> core_state=IDLE, pc=0, mask=0, depth=0 immediately. Restart runs normally.
